// File: rtl/sync_timing_detector.sv
`timescale 1ns/1ps
// Receive-side hSync/vSync/DE timing decoder with active-area coordinates and lock detection.
// Defining SYNC_ERROR_COUNT_EN adds the saturating lock-loss counter port errorCount.
module sync_timing_detector #(
    parameter int busWidth   = 12,
    parameter int lockFrames = 2
) (
    input  logic                pixelClock,
    input  logic                reset,
    input  logic                hSyncIn,
    input  logic                vSyncIn,
    input  logic                dataEnable,
    output logic                activeOut,
    output logic [busWidth-1:0] pixelX,
    output logic [busWidth-1:0] pixelY,
    output logic                frameStart,
    output logic [busWidth-1:0] hTotal,
    output logic [busWidth-1:0] lineLength,
    output logic [busWidth-1:0] frameLines,
    output logic                locked
`ifdef SYNC_ERROR_COUNT_EN
    ,
    output logic [7:0]          errorCount
`endif
);

    localparam logic [busWidth-1:0] CNT_MAX = {busWidth{1'b1}};
    localparam logic [busWidth-1:0] CNT_ONE = {{(busWidth-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [3:0] LOCK_TARGET = 4'(lockFrames);

    logic hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic de_prev_q, de_prev_d;
    logic in_vld_q, in_vld_d, prev_vld_q, prev_vld_d;
    logic line_q, line_d;
    logic h_seen_q, h_seen_d;

    logic [busWidth-1:0] h_cycle_q, h_cycle_d;
    logic [busWidth-1:0] x_count_q, x_count_d;
    logic [busWidth-1:0] y_count_q, y_count_d;
    logic [busWidth-1:0] first_h_q, first_h_d;
    logic [busWidth-1:0] first_l_q, first_l_d;
    logic                have_h_q, have_h_d;
    logic                have_l_q, have_l_d;
    logic                frame_err_q, frame_err_d;

    logic [1:0] state_q, state_d;
    logic [3:0] matches_q, matches_d;
    logic [3:0] matches_inc;

    logic                active_q, active_d;
    logic [busWidth-1:0] pixel_x_q, pixel_x_d;
    logic [busWidth-1:0] pixel_y_q, pixel_y_d;
    logic                frame_start_q, frame_start_d;
    logic [busWidth-1:0] h_total_q, h_total_d;
    logic [busWidth-1:0] line_length_q, line_length_d;
    logic [busWidth-1:0] frame_lines_q, frame_lines_d;

    logic hs_rise, vs_rise, de_rise, de_fall, de_act;
    logic sat_h, sat_x, sat_y;
    logic h_cap, h_mis, l_mis;
    logic new_err, err_now, lines_ok;
    logic [busWidth-1:0] y_end;

    always_comb begin
        hs_d       = hSyncIn;
        vs_d       = vSyncIn;
        de_d       = dataEnable;
        hs_prev_d  = hs_q;
        vs_prev_d  = vs_q;
        de_prev_d  = de_q;
        in_vld_d   = 1'b1;
        prev_vld_d = in_vld_q;
    end

    // Edges need two valid samples, so levels already high at release are ignored.
    assign hs_rise = prev_vld_q & hs_q & ~hs_prev_q;
    assign vs_rise = prev_vld_q & vs_q & ~vs_prev_q;
    assign de_rise = prev_vld_q & de_q & ~de_prev_q;
    assign de_fall = line_q & ~de_q;
    assign de_act  = de_q & (line_q | de_rise);
    assign line_d  = de_act;

    always_comb begin
        x_count_d     = x_count_q;
        line_length_d = line_length_q;
        active_d      = de_act;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        sat_x         = 1'b0;
        if (de_act) begin
            pixel_x_d = x_count_q;
            pixel_y_d = y_count_q;
            if (x_count_q == CNT_MAX) begin
                sat_x = 1'b1;
            end else begin
                x_count_d = x_count_q + CNT_ONE;
            end
        end else if (de_fall) begin
            line_length_d = x_count_q;
            x_count_d     = '0;
        end
    end

    // A line ending in the vSync cycle still belongs to the frame being closed.
    always_comb begin
        y_end = y_count_q;
        sat_y = 1'b0;
        if (de_fall) begin
            if (y_count_q == CNT_MAX) begin
                sat_y = 1'b1;
            end else begin
                y_end = y_count_q + CNT_ONE;
            end
        end
        y_count_d     = vs_rise ? '0 : y_end;
        frame_lines_d = vs_rise ? y_end : frame_lines_q;
        frame_start_d = vs_rise;
    end

    always_comb begin
        h_cycle_d = h_cycle_q;
        h_total_d = h_total_q;
        h_seen_d  = h_seen_q;
        sat_h     = 1'b0;
        if (hs_rise) begin
            h_cycle_d = CNT_ONE;
            h_seen_d  = 1'b1;
            if (h_seen_q) begin
                h_total_d = h_cycle_q;
            end
        end else if (h_cycle_q == CNT_MAX) begin
            sat_h = 1'b1;
        end else begin
            h_cycle_d = h_cycle_q + CNT_ONE;
        end
    end

    assign h_cap   = hs_rise & h_seen_q;
    assign h_mis   = h_cap & have_h_q & (h_cycle_q != first_h_q);
    assign l_mis   = de_fall & have_l_q & (x_count_q != first_l_q);
    assign new_err = h_mis | l_mis | sat_h | sat_x | sat_y;
    assign err_now = frame_err_q | new_err;

    // Captures in the vSync cycle are judged against the frame that is ending.
    always_comb begin
        frame_err_d = err_now;
        first_h_d   = first_h_q;
        first_l_d   = first_l_q;
        have_h_d    = have_h_q;
        have_l_d    = have_l_q;
        if (vs_rise) begin
            frame_err_d = 1'b0;
            have_h_d    = 1'b0;
            have_l_d    = 1'b0;
        end else begin
            if (h_cap && !have_h_q) begin
                first_h_d = h_cycle_q;
                have_h_d  = 1'b1;
            end
            if (de_fall && !have_l_q) begin
                first_l_d = x_count_q;
                have_l_d  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        matches_d   = matches_q;
        matches_inc = matches_q + 4'd1;
        lines_ok    = (y_end != '0) && (y_end == frame_lines_q);
        case (state_q)
            ST_SEARCH: begin
                if (vs_rise) begin
                    state_d   = ST_CHECK;
                    matches_d = '0;
                end
            end
            ST_CHECK: begin
                if (vs_rise) begin
                    if (!err_now && lines_ok) begin
                        matches_d = matches_inc;
                        if (matches_inc >= LOCK_TARGET) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        matches_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (err_now || (vs_rise && !lines_ok)) begin
                    state_d   = ST_CHECK;
                    matches_d = '0;
                end
            end
            default: begin
                state_d   = ST_SEARCH;
                matches_d = '0;
            end
        endcase
    end

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            de_q          <= 1'b0;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            de_prev_q     <= 1'b0;
            in_vld_q      <= 1'b0;
            prev_vld_q    <= 1'b0;
            line_q        <= 1'b0;
            h_seen_q      <= 1'b0;
            h_cycle_q     <= '0;
            x_count_q     <= '0;
            y_count_q     <= '0;
            first_h_q     <= '0;
            first_l_q     <= '0;
            have_h_q      <= 1'b0;
            have_l_q      <= 1'b0;
            frame_err_q   <= 1'b0;
            state_q       <= ST_SEARCH;
            matches_q     <= '0;
            active_q      <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            frame_start_q <= 1'b0;
            h_total_q     <= '0;
            line_length_q <= '0;
            frame_lines_q <= '0;
        end else begin
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            de_q          <= de_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            de_prev_q     <= de_prev_d;
            in_vld_q      <= in_vld_d;
            prev_vld_q    <= prev_vld_d;
            line_q        <= line_d;
            h_seen_q      <= h_seen_d;
            h_cycle_q     <= h_cycle_d;
            x_count_q     <= x_count_d;
            y_count_q     <= y_count_d;
            first_h_q     <= first_h_d;
            first_l_q     <= first_l_d;
            have_h_q      <= have_h_d;
            have_l_q      <= have_l_d;
            frame_err_q   <= frame_err_d;
            state_q       <= state_d;
            matches_q     <= matches_d;
            active_q      <= active_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            frame_start_q <= frame_start_d;
            h_total_q     <= h_total_d;
            line_length_q <= line_length_d;
            frame_lines_q <= frame_lines_d;
        end
    end

`ifdef SYNC_ERROR_COUNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       lock_lost;

    assign lock_lost = (state_q == ST_LOCKED) && (state_d == ST_CHECK);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (lock_lost && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign errorCount = err_cnt_q;
`endif

    assign activeOut  = active_q;
    assign pixelX     = pixel_x_q;
    assign pixelY     = pixel_y_q;
    assign frameStart = frame_start_q;
    assign hTotal     = h_total_q;
    assign lineLength = line_length_q;
    assign frameLines = frame_lines_q;
    assign locked     = (state_q == ST_LOCKED);

endmodule
